regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Issue-side hazard controller for the 2-read/1-write DLX register file.
//  Tracks pending destination registers (busy bits) and reserves the single
//  write port through a latency-indexed reservation shift register.
//  Stalls issue on RAW, WAW and write-port conflicts. Drives the regfile
//  R1/R2/RE1/RE2 read controls and the W/WE write controls.
//  Sits between the decode/issue stage and the register file in dpath1.
// PARAMETERS
//  M      5   register address width
//  WORDS  32  number of architectural registers; register 0 is hardwired zero
//  LMAX   8   reservation slots; legal result latency 1..LMAX-1
//  LW     3   ISSUE_LAT width; must satisfy 2**LW == LMAX
// PORTS
//  CLK          in   1      clock, rising edge
//  RST_N        in   1      asynchronous active-low reset
//  ISSUE_VALID  in   1      instruction presented for issue
//  ISSUE_RS1    in   M      source 1 register
//  ISSUE_USE1   in   1      source 1 is read
//  ISSUE_RS2    in   M      source 2 register
//  ISSUE_USE2   in   1      source 2 is read
//  ISSUE_WR     in   1      instruction writes ISSUE_RD
//  ISSUE_RD     in   M      destination register
//  ISSUE_LAT    in   LW     cycles from accept to write-back (0 is treated as 1)
//  FLUSH        in   1      squash all in-flight writes
//  ISSUE_STALL  out  1      issue blocked this cycle
//  ISSUE_ACCEPT out  1      ISSUE_VALID & !ISSUE_STALL
//  R1, R2       out  M      regfile read addresses (= ISSUE_RS1/ISSUE_RS2)
//  RE1, RE2     out  1      ISSUE_ACCEPT & ISSUE_USE1 / ISSUE_USE2
//  W            out  M      regfile write address (= tag of slot 0)
//  WE           out  1      regfile write enable (= slot 0 valid & !FLUSH)
//  BUSY_VEC     out  WORDS  pending-write bit per register; bit 0 always 0
//  IDLE         out  1      no slot valid
// BEHAVIOUR
//  State: res[LMAX-1:0] valid bits; tag[k] (M bits) per slot; busy[WORDS-1:0].
//  Reset (RST_N low, asynchronous): res, tag and busy are cleared.
//   While in reset: WE=0, W=0, BUSY_VEC=0, IDLE=1.
//   While in reset, the remaining outputs are combinational from the inputs.
//  Let L = (ISSUE_LAT==0) ? 1 : ISSUE_LAT. Let wr = ISSUE_WR & (ISSUE_RD!=0).
//  ISSUE_STALL = ISSUE_VALID & (FLUSH | raw | waw | struct), where:
//   raw    = (USE1 & busy[RS1]) | (USE2 & busy[RS2]); busy[0] is never set.
//   waw    = wr & busy[RD].
//   struct = wr & res[L], using the pre-shift slot index.
//  Every rising edge (no FLUSH):
//   - res[k] <= res[k+1] and tag[k] <= tag[k+1]; the top slot fills with 0.
//   - If ISSUE_ACCEPT & wr: res[L-1] <= 1, tag[L-1] <= RD, busy[RD] <= 1.
//   - If WE: busy[W] <= 0.
//  Timing: a write accepted in cycle t drives WE=1, W=RD during cycle t+L.
//   The busy bit clears at the end of cycle t+L.
//   A dependent read is accepted no earlier than cycle t+L+1.
//   Set and clear of the same register in one cycle cannot occur (WAW stall).
//   A clear of reg A and a set of reg B in the same cycle both take effect.
//  Accepted instruction with ISSUE_WR=0 or RD=0: no reservation, no busy, no WE.
//  FLUSH (synchronous): WE is forced 0 in that cycle and no accept occurs.
//   At the edge, res and busy are cleared; IDLE=1 the next cycle.
//  IDLE = ~|res. Outputs R1/R2 pass through the inputs unconditionally.
// TESTING
//  1 Reset mid-flight: 3 writes in flight, RST_N low between edges
//    -> WE=0, BUSY_VEC=0, IDLE=1 at once; no WE after release.
//  2 RAW: c0 accept RD=5 LAT=3; c1 RS1=5 USE1=1
//    -> STALL c1..c3; WE=1, W=5 in c3; accept c4 with RE1=1, R1=5.
//  3 Write-port conflict: c0 RD=3 LAT=3; c1 RD=4 LAT=2
//    -> STALL c1; accept c2; WE W=3 in c3, WE W=4 in c4.
//  4 WAW: c0 RD=7 LAT=5; c1 RD=7 LAT=1
//    -> STALL c1..c5; accept c6; WE W=7 in c5 and again in c7.
//  5 R0: accept RD=0 WR=1 LAT=2, next cycle RS1=0
//    -> no stall, no WE, BUSY_VEC[0]=0.
//  6 Flush: RD=2 LAT=4 and RD=9 LAT=6 in flight, FLUSH pulse in c2
//    -> no WE for either; BUSY_VEC=0 and IDLE=1 from c3.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Issue-side hazard controller for the 2-read/1-write register file.
//   Keeps one busy bit per architectural register for pending writes and
//   reserves the single write port with a latency-indexed shift register
//   (slot k is the write that happens k cycles from now).
//   Issue stalls on RAW, WAW, write-port conflicts and on flush.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   issue_valid             instruction presented for issue
//   issue_rs1/use1          source 1 address / source 1 is read
//   issue_rs2/use2          source 2 address / source 2 is read
//   issue_wr/rd/lat         writes rd, result latency (0 treated as 1)
//   flush                   squash all in-flight writes
//   issue_stall/accept      issue blocked / instruction taken this cycle
//   r1, r2, re1, re2        register file read controls
//   w, we                   register file write controls (slot 0)
//   busy_vec                pending-write bit per register, bit 0 always 0
//   idle                    no reservation slot valid
module regfile_scoreboard #(
   parameter int M     = 5,
   parameter int WORDS = 32,
   parameter int LMAX  = 8,
   parameter int LW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [M-1:0]     issue_rs1,
   input  logic             issue_use1,
   input  logic [M-1:0]     issue_rs2,
   input  logic             issue_use2,
   input  logic             issue_wr,
   input  logic [M-1:0]     issue_rd,
   input  logic [LW-1:0]    issue_lat,
   input  logic             flush,
   output logic             issue_stall,
   output logic             issue_accept,
   output logic [M-1:0]     r1,
   output logic [M-1:0]     r2,
   output logic             re1,
   output logic             re2,
   output logic [M-1:0]     w,
   output logic             we,
   output logic [WORDS-1:0] busy_vec,
   output logic             idle
);

   logic [LMAX-1:0]  res;
   logic [M-1:0]     tag [LMAX];
   logic [WORDS-1:0] busy;

   logic [LW-1:0]    lat_eff;
   logic [LW-1:0]    slot_new;
   logic             wr;
   logic             raw;
   logic             waw;
   logic             port_conflict;

   always_comb begin
      lat_eff  = (issue_lat == '0) ? LW'(1) : issue_lat;
      // after this edge's shift, the write lands L-1 slots from the bottom
      slot_new = lat_eff - LW'(1);
      wr       = issue_wr & (issue_rd != '0);
      raw      = (issue_use1 & busy[issue_rs1]) | (issue_use2 & busy[issue_rs2]);
      waw      = wr & busy[issue_rd];
      // pre-shift index: slot L now becomes slot L-1 at the edge
      port_conflict = wr & res[lat_eff];
   end

   assign issue_stall  = issue_valid & (flush | raw | waw | port_conflict);
   assign issue_accept = issue_valid & ~issue_stall;
   assign r1           = issue_rs1;
   assign r2           = issue_rs2;
   assign re1          = issue_accept & issue_use1;
   assign re2          = issue_accept & issue_use2;
   assign w            = tag[0];
   assign we           = res[0] & ~flush;
   assign busy_vec     = {busy[WORDS-1:1], 1'b0};
   assign idle         = ~|res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res  <= '0;
         busy <= '0;
         for (int k = 0; k < LMAX; k++) tag[k] <= '0;
      end else if (flush) begin
         res  <= '0;
         busy <= '0;
         for (int k = 0; k < LMAX; k++) tag[k] <= '0;
      end else begin
         res <= {1'b0, res[LMAX-1:1]};
         for (int k = 0; k < LMAX-1; k++) tag[k] <= tag[k+1];
         tag[LMAX-1] <= '0;
         // a clear and a set never hit the same register: that case is a WAW stall
         if (we) busy[w] <= 1'b0;
         if (issue_accept && wr) begin
            res[slot_new] <= 1'b1;
            tag[slot_new] <= issue_rd;
            busy[issue_rd] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_rs1;
   logic        issue_use1;
   logic [4:0]  issue_rs2;
   logic        issue_use2;
   logic        issue_wr;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_lat;
   logic        flush;
   logic        issue_stall;
   logic        issue_accept;
   logic [4:0]  r1;
   logic [4:0]  r2;
   logic        re1;
   logic        re2;
   logic [4:0]  w;
   logic        we;
   logic [31:0] busy_vec;
   logic        idle;

   regfile_scoreboard #(.M(5), .WORDS(32), .LMAX(8), .LW(3)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
      .issue_rs1(issue_rs1), .issue_use1(issue_use1),
      .issue_rs2(issue_rs2), .issue_use2(issue_use2),
      .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_lat(issue_lat),
      .flush(flush), .issue_stall(issue_stall), .issue_accept(issue_accept),
      .r1(r1), .r2(r2), .re1(re1), .re2(re2), .w(w), .we(we),
      .busy_vec(busy_vec), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       wr;
      logic [4:0] rd;
      logic [2:0] lat;
      logic       fl;
      logic       e_stall;
      logic       e_we;
      logic [4:0] e_w;
   } vec_t;

   // reference model: list of pending writes with the absolute cycle of write-back
   typedef struct {
      int r;
      int due;
   } pend_t;

   pend_t pq[$];
   int    now;
   int    n_cmp;
   int    n_bad;
   bit    m_acc;
   bit    m_wr;
   int    m_lat;
   vec_t  tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, now, act, exp);
      end
   endtask

   function automatic bit m_busy(input int r);
      if (r == 0) return 1'b0;
      foreach (pq[i]) if (pq[i].r == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_due(input int t);
      foreach (pq[i]) if (pq[i].due == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_due_reg(input int t);
      foreach (pq[i]) if (pq[i].due == t) return pq[i].r;
      return 0;
   endfunction

   function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic wr, input logic [4:0] rd, input logic [2:0] lat,
                               input logic fl, input logic es, input logic ew,
                               input logic [4:0] eaddr);
      vec_t x;
      x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = 5'd0; x.u2 = 1'b0;
      x.wr = wr; x.rd = rd; x.lat = lat; x.fl = fl;
      x.e_stall = es; x.e_we = ew; x.e_w = eaddr;
      return x;
   endfunction

   task automatic drive(input vec_t x);
      issue_valid = x.v;  issue_rs1 = x.rs1; issue_use1 = x.u1;
      issue_rs2   = x.rs2; issue_use2 = x.u2; issue_wr = x.wr;
      issue_rd    = x.rd; issue_lat = x.lat; flush = x.fl;
   endtask

   task automatic model_check();
      bit e_raw, e_waw, e_str, e_stall, e_we;
      logic [31:0] e_busy;
      m_lat   = (issue_lat == 3'd0) ? 1 : int'(issue_lat);
      m_wr    = issue_wr && (issue_rd != 5'd0);
      e_raw   = (issue_use1 && m_busy(int'(issue_rs1))) || (issue_use2 && m_busy(int'(issue_rs2)));
      e_waw   = m_wr && m_busy(int'(issue_rd));
      e_str   = m_wr && m_due(now + m_lat);
      e_stall = issue_valid && (flush || e_raw || e_waw || e_str);
      m_acc   = issue_valid && !e_stall;
      e_we    = !flush && m_due(now);
      e_busy  = '0;
      for (int r = 1; r < 32; r++) e_busy[r] = m_busy(r);
      chk("stall",  32'(issue_stall),  32'(e_stall));
      chk("accept", 32'(issue_accept), 32'(m_acc));
      chk("re1",    32'(re1), 32'(m_acc && issue_use1));
      chk("re2",    32'(re2), 32'(m_acc && issue_use2));
      chk("r1",     32'(r1),  32'(issue_rs1));
      chk("r2",     32'(r2),  32'(issue_rs2));
      chk("we",     32'(we),  32'(e_we));
      if (e_we) chk("w", 32'(w), 32'(m_due_reg(now)));
      chk("busy_vec", busy_vec, e_busy);
      chk("idle",   32'(idle), 32'(pq.size() == 0));
   endtask

   task automatic model_update();
      pend_t nq[$];
      if (flush) begin
         pq.delete();
      end else begin
         foreach (pq[i]) if (pq[i].due != now) nq.push_back(pq[i]);
         if (m_acc && m_wr) nq.push_back('{r: int'(issue_rd), due: now + m_lat});
         pq = nq;
      end
      now++;
   endtask

   task automatic run_cycle(input vec_t x, input bit use_exp, input string tname);
      @(negedge clk);
      drive(x);
      #1;
      model_check();
      if (use_exp) begin
         chk({tname, ".stall"}, 32'(issue_stall), 32'(x.e_stall));
         chk({tname, ".we"},    32'(we),          32'(x.e_we));
         if (x.e_we) chk({tname, ".w"}, 32'(w), 32'(x.e_w));
      end
      model_update();
   endtask

   initial begin
      vec_t nop, x;
      n_cmp = 0; n_bad = 0; now = 0;
      nop = mk(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);

      // reset: outputs combinational from inputs, state outputs at reset values
      rst_n = 1'b0;
      drive(mk(1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 3'd2, 1'b0, 1'b0, 1'b0, 5'd0));
      #3;
      chk("rst.accept", 32'(issue_accept), 32'd1);
      chk("rst.stall",  32'(issue_stall),  32'd0);
      chk("rst.re1",    32'(re1), 32'd1);
      chk("rst.r1",     32'(r1),  32'd3);
      chk("rst.we",     32'(we),  32'd0);
      chk("rst.w",      32'(w),   32'd0);
      chk("rst.busy",   busy_vec, 32'd0);
      chk("rst.idle",   32'(idle), 32'd1);
      drive(nop);
      #9 rst_n = 1'b1;

      // RAW
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd5, 3'd3, 0, 0, 0, 5'd0));
      tbl.push_back(mk(1, 5'd5, 1, 0, 5'd0, 3'd0, 0, 1, 0, 5'd0));
      tbl.push_back(mk(1, 5'd5, 1, 0, 5'd0, 3'd0, 0, 1, 0, 5'd0));
      tbl.push_back(mk(1, 5'd5, 1, 0, 5'd0, 3'd0, 0, 1, 1, 5'd5));
      tbl.push_back(mk(1, 5'd5, 1, 0, 5'd0, 3'd0, 0, 0, 0, 5'd0));
      // write-port conflict
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd3, 3'd3, 0, 0, 0, 5'd0));
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd4, 3'd2, 0, 1, 0, 5'd0));
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd4, 3'd2, 0, 0, 0, 5'd0));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 1, 5'd3));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 1, 5'd4));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 5'd0));
      // WAW
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd7, 3'd5, 0, 0, 0, 5'd0));
      for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, 5'd0, 0, 1, 5'd7, 3'd1, 0, 1, 0, 5'd0));
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd7, 3'd1, 0, 1, 1, 5'd7));
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd7, 3'd1, 0, 0, 0, 5'd0));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 1, 5'd7));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 5'd0));
      // register 0 destination, lat 0 treated as 1 elsewhere
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd0, 3'd2, 0, 0, 0, 5'd0));
      tbl.push_back(mk(1, 5'd0, 1, 0, 5'd0, 3'd0, 0, 0, 0, 5'd0));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 5'd0));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 5'd0));
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd6, 3'd0, 0, 0, 0, 5'd0));
      tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 1, 5'd6));
      // flush
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd2, 3'd4, 0, 0, 0, 5'd0));
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd9, 3'd6, 0, 0, 0, 5'd0));
      tbl.push_back(mk(1, 5'd0, 0, 1, 5'd20, 3'd1, 1, 1, 0, 5'd0));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 5'd0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 5'd0));

      foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // reset asserted between edges with three writes in flight
      run_cycle(mk(1, 5'd0, 0, 1, 5'd10, 3'd7, 0, 0, 0, 5'd0), 1'b1, "rmf0");
      run_cycle(mk(1, 5'd0, 0, 1, 5'd11, 3'd5, 0, 0, 0, 5'd0), 1'b1, "rmf1");
      run_cycle(mk(1, 5'd0, 0, 1, 5'd12, 3'd3, 0, 0, 0, 5'd0), 1'b1, "rmf2");
      @(negedge clk);
      drive(nop);
      #2 rst_n = 1'b0;
      #1;
      chk("rmf.we",   32'(we),   32'd0);
      chk("rmf.w",    32'(w),    32'd0);
      chk("rmf.busy", busy_vec,  32'd0);
      chk("rmf.idle", 32'(idle), 32'd1);
      pq.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      now += 2;
      for (int i = 0; i < 10; i++) run_cycle(nop, 1'b1, "rmf_post");

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         x = nop;
         x.v   = ($urandom_range(0, 3) != 0);
         x.rs1 = 5'($urandom_range(0, 7));
         x.u1  = 1'($urandom_range(0, 1));
         x.rs2 = 5'($urandom_range(0, 7));
         x.u2  = 1'($urandom_range(0, 1));
         x.wr  = ($urandom_range(0, 3) != 0);
         x.rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         x.lat = 3'($urandom_range(0, 7));
         x.fl  = ($urandom_range(0, 59) == 0);
         run_cycle(x, 1'b0, "rand");
      end

      drive(nop);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
